// File: rtl/program_counter_pkg.sv
// Shared constants for the program counter: default bus width, reset vector
// and the instruction size that defines word alignment.
package program_counter_pkg;

  localparam int          WORD_LEN     = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          INSTR_BYTES  = 4;
  // Number of low address bits that must be zero for an aligned instruction.
  localparam int          ALIGN_BITS   = $clog2(INSTR_BYTES);

endpackage : program_counter_pkg

// File: rtl/pc_align_check.sv
// Word-alignment helper for the program counter. Clears the low address bits
// of the incoming value and keeps a registered flag recording whether the most
// recent load was misaligned. Only instantiated when PC_ALIGN_CHECK_EN is set.
module pc_align_check
  import program_counter_pkg::*;
#(
  parameter int WORD_LEN = program_counter_pkg::WORD_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WORD_LEN-1:0] new_pc,
  output logic [WORD_LEN-1:0] aligned_pc,
  output logic                misaligned
);

  logic misaligned_next;

  // Force the low bits to zero and flag any that were set.
  always_comb begin
    aligned_pc      = {new_pc[WORD_LEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    misaligned_next = |new_pc[ALIGN_BITS-1:0];
  end

  // The flag follows the PC register: cleared on reset, updated on a load, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned <= 1'b0;
    end else if (enable) begin
      misaligned <= misaligned_next;
    end
  end

endmodule : pc_align_check

// File: rtl/program_counter.sv
// Program counter register: loads the caller-supplied next PC on enable,
// holds otherwise, and returns to RESET_VECTOR on a synchronous reset.
// No arithmetic is done here; the fetch/branch logic computes the next value.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds word alignment and the
// pc_misaligned output).
module program_counter
  import program_counter_pkg::*;
#(
  parameter int                  WORD_LEN     = program_counter_pkg::WORD_LEN,
  parameter logic [WORD_LEN-1:0] RESET_VECTOR = program_counter_pkg::RESET_VECTOR[WORD_LEN-1:0]
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WORD_LEN-1:0] newPC,
`ifdef PC_ALIGN_CHECK_EN
  output logic [WORD_LEN-1:0] PC,
  output logic                pc_misaligned
`else
  output logic [WORD_LEN-1:0] PC
`endif
);

  logic [WORD_LEN-1:0] load_value;

`ifdef PC_ALIGN_CHECK_EN
  pc_align_check #(
    .WORD_LEN (WORD_LEN)
  ) u_align (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .new_pc     (newPC),
    .aligned_pc (load_value),
    .misaligned (pc_misaligned)
  );
`else
  assign load_value = newPC;
`endif

  // PC register: reset has priority over a load; no load means hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= RESET_VECTOR;
    end else if (enable) begin
      PC <= load_value;
    end
  end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter. Inputs change 1 time unit
// after the rising edge; outputs are checked at the same point, away from the edge.
// Build with PC_ALIGN_CHECK_EN defined to exercise the alignment option.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] newPC;
  logic [31:0] PC;
`ifdef PC_ALIGN_CHECK_EN
  logic        pc_misaligned;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  program_counter dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .newPC  (newPC),
`ifdef PC_ALIGN_CHECK_EN
    .PC            (PC),
    .pc_misaligned (pc_misaligned)
`else
    .PC     (PC)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] value);
    reset  = 1'b0;
    enable = 1'b1;
    newPC  = value;
    edge_step();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    newPC  = 32'h0;
    #1;

    // Reset held for five edges.
    for (int i = 0; i < 5; i++) begin
      edge_step();
      check($sformatf("reset_edge%0d", i), PC, 32'h0000_0000);
    end
`ifdef PC_ALIGN_CHECK_EN
    check("reset_misaligned", {31'b0, pc_misaligned}, 32'h0);
`endif

    // Basic loads with one-cycle latency.
    load(32'h0000_0004);
    check("load_4", PC, 32'h0000_0004);
    load(32'h0000_00A0);
    check("load_A0", PC, 32'h0000_00A0);

    // Hold while newPC changes.
    enable = 1'b0;
    newPC  = 32'h0000_0100;
    edge_step();
    check("hold_edge1", PC, 32'h0000_00A0);
    edge_step();
    check("hold_edge2", PC, 32'h0000_00A0);

    // Load then reset with enable still high: reset wins.
    load(32'h0000_0100);
    check("load_100", PC, 32'h0000_0100);
    reset  = 1'b1;
    enable = 1'b1;
    newPC  = 32'h0000_0200;
    edge_step();
    check("reset_over_load", PC, 32'h0000_0000);
`ifdef PC_ALIGN_CHECK_EN
    check("reset_over_load_mis", {31'b0, pc_misaligned}, 32'h0);
`endif

    // Between-edge glitches on reset and newPC must not reach PC.
    load(32'h0000_0300);
    check("load_300", PC, 32'h0000_0300);
    #1 reset = 1'b1; newPC = 32'h0000_0ABC;
    #1;
    check("glitch_mid1", PC, 32'h0000_0300);
    #1 reset = 1'b0; newPC = 32'h1234_5678;
    #1;
    check("glitch_mid2", PC, 32'h0000_0300);
    enable = 1'b0;
    edge_step();
    check("glitch_after_edge", PC, 32'h0000_0300);

    // Boundary values: all-ones and zero.
    load(32'hFFFF_FFFF);
`ifdef PC_ALIGN_CHECK_EN
    check("load_ones", PC, 32'hFFFF_FFFC);
    check("load_ones_mis", {31'b0, pc_misaligned}, 32'h1);
`else
    check("load_ones", PC, 32'hFFFF_FFFF);
`endif
    load(32'h0000_0000);
    check("load_zero", PC, 32'h0000_0000);

    // Misaligned then aligned load, then hold behaviour of the flag.
    load(32'h0000_0102);
`ifdef PC_ALIGN_CHECK_EN
    check("load_102", PC, 32'h0000_0100);
    check("load_102_mis", {31'b0, pc_misaligned}, 32'h1);
`else
    check("load_102", PC, 32'h0000_0102);
`endif
    load(32'h0000_0104);
    check("load_104", PC, 32'h0000_0104);
`ifdef PC_ALIGN_CHECK_EN
    check("load_104_mis", {31'b0, pc_misaligned}, 32'h0);
`endif
    load(32'h0000_0103);
`ifdef PC_ALIGN_CHECK_EN
    check("load_103", PC, 32'h0000_0100);
    check("load_103_mis", {31'b0, pc_misaligned}, 32'h1);
`else
    check("load_103", PC, 32'h0000_0103);
`endif
    enable = 1'b0;
    newPC  = 32'h0000_0208;
    edge_step();
`ifdef PC_ALIGN_CHECK_EN
    check("hold_103", PC, 32'h0000_0100);
    check("hold_103_mis", {31'b0, pc_misaligned}, 32'h1);
`else
    check("hold_103", PC, 32'h0000_0103);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_program_counter
